// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC step
// and the value driven on the instruction bus when nothing is live.
`timescale 1ns/1ps

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its PC while the
// decode-facing output register is occupied and stalled.
`timescale 1ns/1ps

module fetch_skid
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_unload,
    input  logic                  i_flush,
    input  logic [31:0]           i_data,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [31:0]           o_data,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_full
);

    // Flush wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_data <= NOP_INSTR;
            o_pc   <= '0;
            o_full <= 1'b0;
        end else if (i_flush) begin
            o_full <= 1'b0;
        end else if (i_load) begin
            o_data <= i_data;
            o_pc   <= i_pc;
            o_full <= 1'b1;
        end else if (i_unload) begin
            o_full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, masters instruction memory over a
// req/ack handshake and drives the registered output stage to decode.
`timescale 1ns/1ps

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  oIM_req,
    output logic [ADDR_WIDTH-1:0] oIM_addr,
    input  logic                  iIM_ack,
    input  logic [31:0]           iIM_rdata,
    input  logic                  iSTALL,
    input  logic                  iREDIRECT_valid,
    input  logic [ADDR_WIDTH-1:0] iREDIRECT_pc,
    output logic [31:0]           oINSTR,
    output logic [ADDR_WIDTH-1:0] oINSTR_pc,
    output logic                  oINSTR_valid
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_squash;

    logic                  w_consume;
    logic                  w_oFree;
    logic                  w_ackLive;
    logic [ADDR_WIDTH-1:0] w_pcNext;
    logic [ADDR_WIDTH-1:0] w_redirPc;
    logic                  w_skidLoad;
    logic                  w_skidUnload;
    logic                  w_skidFull;
    logic [31:0]           w_skidData;
    logic [ADDR_WIDTH-1:0] w_skidPc;

    assign w_consume    = oINSTR_valid & ~iSTALL;
    assign w_oFree      = ~oINSTR_valid | w_consume;
    assign w_ackLive    = (r_state == FETCH) & iIM_ack & ~r_squash;
    assign w_pcNext     = r_pc + ADDR_WIDTH'(PC_INC);
    assign w_redirPc    = iREDIRECT_pc & ~ADDR_WIDTH'(3);
    assign w_skidLoad   = ~iREDIRECT_valid & w_ackLive & ~w_oFree;
    assign w_skidUnload = ~iREDIRECT_valid & (r_state == HOLD) & w_consume;

    fetch_skid #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_skidLoad),
        .i_unload (w_skidUnload),
        .i_flush  (iREDIRECT_valid),
        .i_data   (iIM_rdata),
        .i_pc     (oIM_addr),
        .o_data   (w_skidData),
        .o_pc     (w_skidPc),
        .o_full   (w_skidFull)
    );

    // A redirect during an un-acked request cannot withdraw it, so the
    // request is left running and its eventual data is squashed instead.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            oIM_req      <= 1'b0;
            oIM_addr     <= RESET_PC;
            oINSTR       <= NOP_INSTR;
            oINSTR_pc    <= '0;
            oINSTR_valid <= 1'b0;
        end else if (iREDIRECT_valid) begin
            r_pc         <= w_redirPc;
            oINSTR       <= NOP_INSTR;
            oINSTR_valid <= 1'b0;
            if ((r_state == FETCH) && !iIM_ack) begin
                r_squash <= 1'b1;
            end else begin
                r_squash <= 1'b0;
                r_state  <= FETCH;
                oIM_req  <= 1'b1;
                oIM_addr <= w_redirPc;
            end
        end else begin
            if (w_consume) begin
                oINSTR       <= NOP_INSTR;
                oINSTR_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH;
                    oIM_req  <= 1'b1;
                    oIM_addr <= r_pc;
                end
                FETCH: begin
                    if (iIM_ack && r_squash) begin
                        r_squash <= 1'b0;
                        oIM_addr <= r_pc;
                    end else if (w_ackLive) begin
                        r_pc <= w_pcNext;
                        if (w_oFree) begin
                            oINSTR       <= iIM_rdata;
                            oINSTR_pc    <= oIM_addr;
                            oINSTR_valid <= 1'b1;
                            oIM_addr     <= w_pcNext;
                        end else begin
                            oIM_req <= 1'b0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_consume) begin
                        oINSTR       <= w_skidData;
                        oINSTR_pc    <= w_skidPc;
                        oINSTR_valid <= 1'b1;
                        oIM_req      <= 1'b1;
                        oIM_addr     <= r_pc;
                        r_state      <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    oIM_req <= 1'b0;
                end
            endcase
        end
    end

    // The skid entry only exists while parked in HOLD, and a request is live exactly in FETCH.
    assert property (@(posedge clock) disable iff (!reset) (r_state == FETCH) |-> !w_skidFull);
    assert property (@(posedge clock) disable iff (!reset) oIM_req == (r_state == FETCH));

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents fetched instructions to the decode stage. It is the producer side of the first pipeline register wall. That wall samples `oINSTR` on the falling clock edge, so every output here is registered on the rising edge. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled. Branch redirects squash all in-flight work.

## Interface
- `ADDR_WIDTH`, default 32: PC and memory address width, byte addressed.
- `RESET_PC`, default 0: first fetch address after reset; must be word aligned.

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `oIM_req`  out  1: read request to instruction memory.
- `oIM_addr`  out  ADDR_WIDTH: read address; stable while `oIM_req` is high and `iIM_ack` is low.
- `iIM_ack`  in  1: read complete; `iIM_rdata` is valid in the same cycle.
- `iIM_rdata`  in  32: instruction word.
- `iSTALL`  in  1: decode cannot accept; the output register is held.
- `iREDIRECT_valid`  in  1: branch or jump taken, one-cycle pulse.
- `iREDIRECT_pc`  in  ADDR_WIDTH: redirect target; bits [1:0] are ignored and forced to 0.
- `oINSTR`  out  32: instruction to decode.
- `oINSTR_pc`  out  ADDR_WIDTH: address of `oINSTR`.
- `oINSTR_valid`  out  1: `oINSTR` holds a live instruction.

## Operation
- Storage:
  - `pc`: next fetch address.
  - `oIM_addr`: outstanding request address.
  - Output register O: `oINSTR`, `oINSTR_pc`, `oINSTR_valid`.
  - Skid register S: data, pc, full.
  - `squash` flag.
- Reset values:
  - `pc` = RESET_PC, `oIM_addr` = RESET_PC.
  - `oIM_req` = 0, `oINSTR` = 0, `oINSTR_pc` = 0, `oINSTR_valid` = 0.
  - S empty, `squash` = 0, state = IDLE.
- O is consumed at a rising edge when `oINSTR_valid` is high and `iSTALL` is low.
- States:
  - **IDLE**: unconditionally goes to FETCH next cycle. Sets `oIM_req` = 1 and `oIM_addr` = `pc`.
  - **FETCH**: `oIM_req` is high. With no ack, hold everything.
    - On ack with `squash` = 0, `pc` += 4 (mod 2^ADDR_WIDTH).
    - If O is empty or consumed this cycle, the data goes to O. Stay in FETCH and issue the next request back-to-back: `oIM_addr` = new `pc`, `oIM_req` stays 1.
    - Otherwise the data goes to S, `oIM_req` drops, and the state becomes HOLD.
  - **HOLD**: `oIM_req` = 0. When O is consumed, S moves to O, S empties, and the state becomes FETCH with a request at `pc`.
- Redirect has highest priority in every state:
  - `pc` = `iREDIRECT_pc`; O and S are invalidated.
  - FETCH with no ack this cycle: the request cannot be withdrawn. `oIM_req` and `oIM_addr` hold and `squash` = 1. The acked data is discarded, `squash` clears, and a new request issues at `pc` in the next cycle.
  - FETCH with ack in the same cycle: the data is discarded, no squash is needed, and the next request goes to the new `pc`.
  - IDLE or HOLD: go to FETCH at the new `pc`.
- Redirect in the same cycle as a consume: the consume still counts for decode, and O ends up invalid.
- S is never full while in FETCH, so at most one instruction is buffered beyond O.
- `reset` asserted mid-transaction: all state returns to reset values immediately. Memory must tolerate `oIM_req` dropping without ack.

## Timing
- First `oIM_req` rises at the first rising edge after `reset` deasserts. IDLE lasts exactly one cycle.
- Ack-to-output latency: the data is registered at the ack edge, so `oINSTR_valid` is high in the following cycle.
- Throughput is one instruction per cycle with a zero-wait memory (ack in the first request cycle) and `iSTALL` low.
- Redirect to first new-target request:
  - same edge if no request is outstanding;
  - otherwise the cycle after the pending ack.
- All outputs change only on the rising edge. Decode's register wall samples them at the falling edge, giving half a cycle of settle.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, FETCH, HOLD};
  - `PC_INC` = 4;
  - `NOP_INSTR` (reset/invalid value driven on `oINSTR` is 0).
- Sub-module `fetch_skid`: one-entry data+pc buffer with load, unload and flush. The rest (FSM, PC, O register) stays in `instr_fetch`.

## Test plan
- Reset release, zero-wait memory, `iSTALL` = 0: `oIM_addr` = 0, 4, 8 on consecutive cycles; `oINSTR_pc` = 0, 4, 8 one cycle later; `oINSTR_valid` held high.
- `iSTALL` high for 3 cycles while two acks arrive: O is held, the second word enters S, `oIM_req` drops (HOLD). On release, the words emerge in order with no loss or duplication.
- Redirect to 0x100 while a request to 0x10 waits 2 cycles for ack: `oIM_addr` stays 0x10 until ack, the data is discarded, the next request is 0x100, and `oINSTR_pc` = 0x100 appears next.
- Redirect to 0x203 coincident with ack: ack data is dropped, the next request is 0x200, O and S are empty.
- PC at 0xFFFFFFFC: the next fetch address wraps to 0x00000000.
- `reset` asserted during HOLD with S full: all outputs are 0 at once; after release the first request is RESET_PC.
